counter_cmd_arbiter: RTL and testbench
======================================

# counter_cmd_arbiter

Round-robin controller that shares one up/down load counter among NREQ requesters. Each requester issues LOAD/INC/DEC/READ commands over a valid/ready handshake. The block serialises them onto the counter's load_n/ce/up_down/data_load controls and returns the post-operation count to the winning requester. It sits directly in front of the counter; it is the counter's only control source.

## Interface
- WIDTH, 4, counter data width; must match the counter.
- NREQ, 4, number of requesters, 2..8.
- SATURATE, 0, when 1, INC at max and DEC at zero are blocked and flagged.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester command valid.
- req_op  in  NREQ×2  per-requester op: 0 LOAD, 1 INC, 2 DEC, 3 READ.
- req_data  in  NREQ×WIDTH  per-requester load value; used only for LOAD.
- req_ready  out  NREQ  one-hot grant; a command transfers when valid&ready.
- load_n  out  1  to counter, active-low load.
- ce  out  1  to counter, count enable.
- up_down  out  1  to counter, 1 = up.
- data_load  out  WIDTH  to counter, load value.
- count_out  in  WIDTH  from counter.
- zero  in  1  from counter, count_out==0.
- max_count  in  1  from counter, count_out==all ones.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  $clog2(NREQ)  index of the requester being answered.
- rsp_count  out  WIDTH  count_out sampled in the RESP cycle.
- rsp_err  out  1  saturation block occurred; SATURATE=1 only.

## Operation
- FSM states are ARB, DRIVE and RESP.
- ARB: if any req_valid, assert req_ready for exactly one requester, chosen round-robin. The search starts at the index after the last granted requester. On transfer, capture op, data and id, then go to DRIVE. With no valid request, stay in ARB.
- DRIVE (1 cycle): registered counter controls are active.
  - LOAD: load_n=0, data_load=data.
  - INC: ce=1, up_down=1.
  - DEC: ce=1, up_down=0.
  - READ: no control asserted.
  - Go to RESP.
- RESP (1 cycle): rsp_valid=1, with rsp_id and rsp_count=count_out. Return to ARB. The grant pointer advances only on a transfer.
- Saturation (SATURATE=1): in DRIVE, if op is INC and max_count=1, or op is DEC and zero=1, ce stays 0 and rsp_err=1 in RESP. With SATURATE=0 the counter wraps: all-ones INC gives 0, 0 DEC gives all-ones. rsp_err is always 0.
- Idle control values in ARB and RESP: load_n=1, ce=0, up_down=1, data_load=0.
- req_ready is 0 outside ARB. Requests are never dropped; a requester holds valid until it is granted.

## Timing
- Reset, asynchronous: state goes to ARB and the pointer to requester 0 (highest priority). Outputs reset to:
  - load_n=1, ce=0, up_down=1, data_load=0;
  - req_ready=0, which is registered low during reset;
  - rsp_valid=0, rsp_id=0, rsp_count=0, rsp_err=0.
- Transfer at edge T: controls are active in cycle T..T+1, the counter updates at edge T+1, rsp_valid is high in cycle T+1..T+2.
- Throughput is one command per 3 cycles. Latency is 2 cycles from transfer to response.
- Reset mid-operation: any in-flight command is abandoned, no response is issued, and the counter controls return to idle immediately.
- A simultaneous valid on all requesters is served strictly in rotation. No requester waits more than NREQ-1 commands.
- req_ready is combinational from req_valid and the pointer, gated by state==ARB.

## Structure
- Package counter_ctrl_pkg holds:
  - op_t enum (OP_LOAD, OP_INC, OP_DEC, OP_READ);
  - state_t enum (ARB, DRIVE, RESP);
  - idle control constants.
- Sub-module rr_arbiter (NREQ): request vector plus advance strobe in, one-hot grant and encoded index out. It owns the pointer register.
- The top level holds the FSM, the command capture registers and the counter control registers.

## Test plan
- Reset, then requester 0 issues LOAD 4'hA: load_n=0 for one cycle, then rsp_valid with id=0, count=4'hA.
- All 4 requesters assert INC simultaneously from count 0: grants go 0,1,2,3 and responses return counts 1,2,3,4.
- SATURATE=0, LOAD 4'hF then INC: rsp_count=0. DEC from 0 gives 4'hF.
- SATURATE=1, LOAD 4'hF then INC: ce stays 0, rsp_count=4'hF, rsp_err=1. The same check applies for DEC at 0.
- READ after LOAD 4'h5: no control asserted, rsp_count=5, and the counter is unchanged.
- Assert rst_n low during DRIVE of an INC: controls go idle at once, no rsp_valid appears, the next grant goes to requester 0, and the count is unchanged.

Source files
------------

// File: rtl/counter_cmd_arbiter_pkg.sv
// rtl/counter_cmd_arbiter_pkg.sv - shared types and idle control values for the counter command arbiter
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_READ = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic IDLE_LOAD_N  = 1'b1;
  localparam logic IDLE_CE      = 1'b0;
  localparam logic IDLE_UP_DOWN = 1'b1;

endpackage

// File: rtl/counter_cmd_arbiter_if.sv
// rtl/counter_cmd_arbiter_if.sv - requester command and response bus
interface counter_cmd_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][1:0]       req_op;
  logic [NREQ-1:0][WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       rsp_valid;
  logic [IDW-1:0]             rsp_id;
  logic [WIDTH-1:0]           rsp_count;
  logic                       rsp_err;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_id, rsp_count, rsp_err
  );
endinterface

// File: rtl/counter_cmd_arbiter_rr.sv
// rtl/counter_cmd_arbiter_rr.sv - round-robin grant selection with its own rotating pointer
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;
  logic           found;

  // Search begins at ptr, which sits one past the last granted requester.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end
endmodule

// File: rtl/counter_cmd_arbiter.sv
// rtl/counter_cmd_arbiter.sv - serialises requester commands onto a shared up/down load counter
module counter_cmd_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NREQ     = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  counter_cmd_arbiter_if.slave bus,
  output logic                 load_n,
  output logic                 ce,
  output logic                 up_down,
  output logic [WIDTH-1:0]     data_load,
  input  logic [WIDTH-1:0]     count_out,
  input  logic                 zero,
  input  logic                 max_count
);
  localparam int IDW = $clog2(NREQ);

  state_t           state, state_nxt;
  logic             armed;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             transfer;
  op_t              sel_op;
  logic [WIDTH-1:0] sel_data;
  logic             blocked;
  logic [IDW-1:0]   cap_id;
  logic             cap_err;
  logic             load_n_nxt, ce_nxt, up_down_nxt;
  logic [WIDTH-1:0] data_load_nxt;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req_valid),
    .advance  (transfer),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Controls are computed at the transfer edge so they are registered for the DRIVE cycle;
  // the count cannot change before then, so the flags seen now are the ones DRIVE would see.
  always_comb begin
    state_nxt     = state;
    transfer      = 1'b0;
    sel_op        = op_t'(bus.req_op[grant_id]);
    sel_data      = bus.req_data[grant_id];
    blocked       = SATURATE && ((sel_op == OP_INC && max_count) || (sel_op == OP_DEC && zero));
    load_n_nxt    = IDLE_LOAD_N;
    ce_nxt        = IDLE_CE;
    up_down_nxt   = IDLE_UP_DOWN;
    data_load_nxt = '0;
    case (state)
      ARB: begin
        if (armed && |grant) begin
          transfer  = 1'b1;
          state_nxt = DRIVE;
          if (!blocked) begin
            case (sel_op)
              OP_LOAD: begin
                load_n_nxt    = 1'b0;
                data_load_nxt = sel_data;
              end
              OP_INC: ce_nxt = 1'b1;
              OP_DEC: begin
                ce_nxt      = 1'b1;
                up_down_nxt = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      DRIVE:   state_nxt = RESP;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      armed     <= 1'b0;
      cap_id    <= '0;
      cap_err   <= 1'b0;
      load_n    <= IDLE_LOAD_N;
      ce        <= IDLE_CE;
      up_down   <= IDLE_UP_DOWN;
      data_load <= '0;
    end else begin
      state     <= state_nxt;
      armed     <= 1'b1;
      load_n    <= load_n_nxt;
      ce        <= ce_nxt;
      up_down   <= up_down_nxt;
      data_load <= data_load_nxt;
      if (transfer) begin
        cap_id  <= grant_id;
        cap_err <= blocked;
      end
    end
  end

  // armed keeps grants off while reset is held and for the first edge after release.
  assign bus.req_ready = (state == ARB && armed) ? grant : '0;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = (state == RESP) ? cap_id : '0;
  assign bus.rsp_count = (state == RESP) ? count_out : '0;
  assign bus.rsp_err   = (state == RESP) && cap_err;
endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// tb/tb_counter_cmd_arbiter.sv - directed bench driving a wrapping and a saturating instance in lockstep
module tb_counter_cmd_arbiter;
  import counter_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_cmd_arbiter_if #(.WIDTH(4), .NREQ(4)) bus0 ();
  counter_cmd_arbiter_if #(.WIDTH(4), .NREQ(4)) bus1 ();

  logic       load_n0, ce0, up_down0, load_n1, ce1, up_down1;
  logic [3:0] data_load0, data_load1, cnt0, cnt1;

  counter_cmd_arbiter #(.WIDTH(4), .NREQ(4), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .load_n(load_n0), .ce(ce0), .up_down(up_down0), .data_load(data_load0),
    .count_out(cnt0), .zero(cnt0 == 4'd0), .max_count(&cnt0)
  );

  counter_cmd_arbiter #(.WIDTH(4), .NREQ(4), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .load_n(load_n1), .ce(ce1), .up_down(up_down1), .data_load(data_load1),
    .count_out(cnt1), .zero(cnt1 == 4'd0), .max_count(&cnt1)
  );

  // Counter models with their own reset, so arbiter resets leave the count alone.
  always @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n)       cnt0 <= 4'd0;
    else if (!load_n0)    cnt0 <= data_load0;
    else if (ce0)         cnt0 <= up_down0 ? cnt0 + 4'd1 : cnt0 - 4'd1;
  end

  always @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n)       cnt1 <= 4'd0;
    else if (!load_n1)    cnt1 <= data_load1;
    else if (ce1)         cnt1 <= up_down1 ? cnt1 + 4'd1 : cnt1 - 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [1:0] op, input logic [3:0] data);
    bus0.req_valid[id] = v;  bus1.req_valid[id] = v;
    bus0.req_op[id]    = op; bus1.req_op[id]    = op;
    bus0.req_data[id]  = data; bus1.req_data[id] = data;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_load_n0"}, load_n0, 1'b1);
    check({tag, "_ce0"}, ce0, 1'b0);
    check({tag, "_up0"}, up_down0, 1'b1);
    check({tag, "_dl0"}, data_load0, 4'h0);
    check({tag, "_load_n1"}, load_n1, 1'b1);
    check({tag, "_ce1"}, ce1, 1'b0);
  endtask

  // Called at a negedge with requests already posted; waits for id's grant and checks the command.
  task automatic serve(input int id, input logic [1:0] op, input logic [3:0] data,
                       input logic [3:0] exp0, input logic [3:0] exp1, input logic err1);
    bit   got;
    logic e_ln, e_ce, e_ud;
    logic [3:0] e_dl;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus0.req_ready[id]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("grant_timeout", 32'd0, 32'd1);
      set_req(id, 1'b0, op, data);
      @(negedge clk);
      return;
    end
    check("ready0", bus0.req_ready, 4'b0001 << id);
    check("ready1", bus1.req_ready, 4'b0001 << id);
    e_ln = (op == OP_LOAD) ? 1'b0 : 1'b1;
    e_ce = (op == OP_INC) || (op == OP_DEC);
    e_ud = (op == OP_DEC) ? 1'b0 : 1'b1;
    e_dl = (op == OP_LOAD) ? data : 4'h0;
    @(posedge clk);
    #1;
    set_req(id, 1'b0, op, data);
    check("drv_load_n0", load_n0, e_ln);
    check("drv_ce0", ce0, e_ce);
    check("drv_up0", up_down0, e_ud);
    check("drv_dl0", data_load0, e_dl);
    check("drv_ce1", ce1, err1 ? 1'b0 : e_ce);
    check("drv_load_n1", load_n1, e_ln);
    check("drv_ready_low", bus0.req_ready, 4'b0000);
    @(posedge clk);
    #1;
    check("rsp_valid0", bus0.rsp_valid, 1'b1);
    check("rsp_id0", bus0.rsp_id, id);
    check("rsp_count0", bus0.rsp_count, exp0);
    check("rsp_err0", bus0.rsp_err, 1'b0);
    check("rsp_valid1", bus1.rsp_valid, 1'b1);
    check("rsp_count1", bus1.rsp_count, exp1);
    check("rsp_err1", bus1.rsp_err, err1);
    check_idle("resp");
    @(posedge clk);
    #1;
    check("rsp_drop0", bus0.rsp_valid, 1'b0);
    @(negedge clk);
  endtask

  task automatic cmd(input int id, input logic [1:0] op, input logic [3:0] data,
                     input logic [3:0] exp0, input logic [3:0] exp1, input logic err1);
    set_req(id, 1'b1, op, data);
    serve(id, op, data, exp0, exp1, err1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, OP_READ, 4'h0);
    set_req(0, 1'b1, OP_LOAD, 4'h3);
    repeat (3) @(negedge clk);
    check("rst_ready0", bus0.req_ready, 4'b0000);
    check("rst_ready1", bus1.req_ready, 4'b0000);
    check("rst_rsp_valid", bus0.rsp_valid, 1'b0);
    check("rst_rsp_id", bus0.rsp_id, 2'd0);
    check("rst_rsp_count", bus0.rsp_count, 4'h0);
    check("rst_rsp_err", bus1.rsp_err, 1'b0);
    check_idle("rst");
    set_req(0, 1'b0, OP_READ, 4'h0);
    rst_n = 1'b1;
    cnt_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cmd(0, OP_LOAD, 4'hA, 4'hA, 4'hA, 1'b0);
    cmd(3, OP_LOAD, 4'h0, 4'h0, 4'h0, 1'b0);

    for (int i = 0; i < 4; i++) set_req(i, 1'b1, OP_INC, 4'h0);
    for (int g = 0; g < 4; g++) serve(g, OP_INC, 4'h0, 4'(g + 1), 4'(g + 1), 1'b0);

    cmd(1, OP_LOAD, 4'hF, 4'hF, 4'hF, 1'b0);
    cmd(2, OP_INC,  4'h0, 4'h0, 4'hF, 1'b1);
    cmd(3, OP_LOAD, 4'h0, 4'h0, 4'h0, 1'b0);
    cmd(0, OP_DEC,  4'h0, 4'hF, 4'h0, 1'b1);

    cmd(1, OP_LOAD, 4'h5, 4'h5, 4'h5, 1'b0);
    cmd(2, OP_READ, 4'h9, 4'h5, 4'h5, 1'b0);
    check("read_cnt_kept", cnt0, 4'h5);

    cmd(0, OP_LOAD, 4'h7, 4'h7, 4'h7, 1'b0);
    set_req(1, 1'b1, OP_INC, 4'h0);
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        #1;
        if (bus0.req_ready[1]) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("mid_grant", got, 1'b1);
    end
    @(posedge clk);
    #1;
    check("mid_drive_ce", ce0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    set_req(1, 1'b0, OP_INC, 4'h0);
    check_idle("mid_rst");
    @(posedge clk);
    #1;
    check("mid_no_rsp_a", bus0.rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    check("mid_no_rsp_b", bus0.rsp_valid, 1'b0);
    check("mid_cnt_kept", cnt0, 4'h7);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_req(0, 1'b1, OP_READ, 4'h0);
    set_req(2, 1'b1, OP_READ, 4'h0);
    serve(0, OP_READ, 4'h0, 4'h7, 4'h7, 1'b0);
    serve(2, OP_READ, 4'h0, 4'h7, 4'h7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
